wb_host_bridge: RTL
===================

Name: wb_host_bridge

Overview:
- Wishbone classic (B3, single-transfer) initiator for the user area.
- Converts a simple valid/ready command channel (from LA-driven control logic or an on-chip sequencer) into one Wishbone read or write cycle towards a user-area Wishbone responder.
- Returns read data plus an error flag on a valid/ready response channel.
- Bounds every bus cycle with an ack timeout, so a dead responder cannot hang the initiator.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles with cyc/stb asserted before the bridge aborts; 0 disables the timeout.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  bridge accepts a command (only in IDLE).
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lane selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_dat_o  out  32  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  1 = cycle aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cyc.
- wbm_stb_o  out  1  Wishbone stb.
- wbm_we_o  out  1  Wishbone we.
- wbm_sel_o  out  4  Wishbone sel.
- wbm_adr_o  out  32  Wishbone adr.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ack.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- FSM states:
  - IDLE -> BUS on cmd_valid_i & cmd_ready_o.
  - BUS -> RESP on ack or timeout.
  - RESP -> IDLE on rsp_valid_o & rsp_ready_i.
- Reset (any state, mid-cycle included) at the next edge:
  - state = IDLE, so cmd_ready_o = 1.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o, wbm_adr_o, wbm_dat_o = 0.
  - rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, busy_o = 0; timeout counter = 0.
  - An in-flight bus cycle is dropped and no response is produced.
- All Wishbone outputs are registered.
- Command acceptance:
  - At accept edge N, command fields are latched into the wbm_* registers and cyc = stb = 1 from edge N.
  - The first bus cycle is therefore the cycle after acceptance.
- BUS state:
  - cyc, stb, we, sel, adr and dat are held stable until termination.
  - The counter increments every BUS cycle without ack.
- Ack termination: wbm_ack_i sampled high at edge M causes, at that edge:
  - cyc = stb = 0 and we = 0.
  - rsp_dat_o = wbm_dat_i for reads, 0 for writes.
  - rsp_err_o = 0, rsp_valid_o = 1.
- Timeout termination: if TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 at an edge with no ack, that edge causes:
  - cyc = stb = 0.
  - rsp_dat_o = 0, rsp_err_o = 1, rsp_valid_o = 1.
  - Net effect: stb is high for exactly TIMEOUT_CYCLES cycles.
- Ack and timeout on the same edge: ack wins, err = 0.
- wbm_ack_i outside BUS (late ack after a timeout, spurious ack) is ignored; no state or output change.
- RESP state:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i is sampled high.
  - On that edge: rsp_valid_o = 0 and the state returns to IDLE. rsp_dat_o and rsp_err_o keep their values (don't-care).
  - cmd_ready_o stays 0 in RESP; there is no command/response overlap.
- Throughput: one transaction in flight. Minimum 3 cycles per transaction with immediate ack and rsp_ready_i held high: accept, bus, resp.
- The counter clears on every entry to BUS.
- Addresses and sel are passed through unmodified; no alignment checks.

Decomposition:
- Package wb_host_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - constant WB_DW = 32, WB_AW = 32, WB_SW = 4;
  - the timeout-response data constant (32'h0).
- One natural sub-module, wb_host_timeout: a counter with clear, enable, and a terminal-count output.
- The FSM and datapath registers stay in the top module.

Test Plan:
1. Reset during BUS (cyc high, no ack), with wb_rst_i high for 1 cycle -> next edge cyc = stb = 0, cmd_ready_o = 1, rsp_valid_o = 0; a later ack causes no response.
2. Write: adr 0x3000_0004, dat 0xA5A5_1234, sel 0xF, ack after 2 bus cycles -> stb high exactly 2 cycles with stable adr/dat/we = 1; then rsp_valid_o = 1, rsp_err_o = 0, rsp_dat_o = 0.
3. Read: adr 0x3000_0008, responder acks on the first bus cycle with 0xDEAD_BEEF, rsp_ready_i held high -> rsp_dat_o = 0xDEAD_BEEF, err = 0, cmd_ready_o high again 3 cycles after accept.
4. Timeout, TIMEOUT_CYCLES = 4, no ack -> stb high exactly 4 cycles, then rsp_err_o = 1, rsp_dat_o = 0; an ack injected 2 cycles later is ignored.
5. Ack on the same edge as timeout (TIMEOUT_CYCLES = 3, ack on the 3rd bus cycle) -> rsp_err_o = 0, read data returned.
6. Response backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o, rsp_dat_o and rsp_err_o stable, cmd_ready_o = 0, a pending cmd_valid_i is not accepted; after ready, the next command is accepted in IDLE.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host bridge: FSM states, bus
// widths and the data word returned on a timed-out cycle.
package wb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_host_state_e;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam int WB_SW = 4;

    localparam logic [WB_DW-1:0] TIMEOUT_RSP_DAT = 32'h0;

endpackage : wb_host_pkg

// File: rtl/wb_host_timeout.sv
// Ack-timeout counter: clears on bus-cycle entry, counts un-acked bus cycles
// and flags the last allowed cycle. TIMEOUT_CYCLES = 0 never flags.
module wb_host_timeout
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

endmodule : wb_host_timeout

// File: rtl/wb_host_bridge.sv
// Single-transfer Wishbone B3 initiator: turns one valid/ready command into one
// bus cycle and returns data/error on a valid/ready response channel.
module wb_host_bridge
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [WB_AW-1:0]  cmd_adr_i,
    input  logic [WB_DW-1:0]  cmd_dat_i,
    input  logic [WB_SW-1:0]  cmd_sel_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WB_DW-1:0]  rsp_dat_o,
    output logic              rsp_err_o,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [WB_SW-1:0]  wbm_sel_o,
    output logic [WB_AW-1:0]  wbm_adr_o,
    output logic [WB_DW-1:0]  wbm_dat_o,
    input  logic [WB_DW-1:0]  wbm_dat_i,
    input  logic              wbm_ack_i,

    output logic              busy_o
);

    wb_host_state_e      state_q;
    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic [WB_SW-1:0]    sel_q;
    logic [WB_AW-1:0]    adr_q;
    logic [WB_DW-1:0]    dat_q;
    logic                rsp_valid_q;
    logic [WB_DW-1:0]    rsp_dat_q;
    logic                rsp_err_q;

    logic                accept;
    logic                tmo_tc;

    assign accept = (state_q == ST_IDLE) && cmd_valid_i;

    wb_host_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .clr_i (accept),
        .en_i  ((state_q == ST_BUS) && !wbm_ack_i),
        .tc_o  (tmo_tc)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state_q <= ST_BUS;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= cmd_we_i;
                        sel_q   <= cmd_sel_i;
                        adr_q   <= cmd_adr_i;
                        dat_q   <= cmd_dat_i;
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so it wins over a same-edge timeout.
                    if (wbm_ack_i) begin
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else if (tmo_tc) begin
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= TIMEOUT_RSP_DAT;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule : wb_host_bridge
